mole_hit_judge: RTL

- Per-mole lifecycle tracker and hit judge; sits directly downstream of the mole generator and upstream of the score keeper and game FSM.
- Takes the generator's bitmap of new moles plus the player's encoded mallet input.
- Runs each of NUM_MOLES moles through OFFSCREEN/ONSCREEN/HIT/MISS with per-mole timers.
- Emits hit/miss pulses for scoring, plus an all-clear flag that triggers the next generation round.

---
 rtl/mole_hit_judge.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mole_hit_judge.sv
// mole_hit_judge: per-mole lifecycle tracker and hit judge.
//   Each of NUM_MOLES moles runs OFFSCREEN -> ONSCREEN -> HIT/MISS -> OFFSCREEN, with a
//   per-mole down-counting timer. The player's encoded mallet input is registered and
//   edge-detected so that one press gives exactly one event.
// Ports:
//   clock, reset (async, active low), clear (sync, active high), enable (low freezes all)
//   load / molesGenerated : spawn strobe and bitmap of moles to spawn
//   userGameInput         : 0 none, 1..5 mole 0..4, 6/7 none
//   moleState             : 2 bits per mole (00 off, 01 on, 10 hit, 11 miss)
//   moleHit / moleMiss / wrongHit : registered one-cycle pulses
//   allClear              : every mole OFFSCREEN (combinational from state)
// Optional feature: define MOLE_SPEEDUP_EN to shorten the ONSCREEN lifetime after each hit.
module mole_hit_judge #(
  parameter int unsigned NUM_MOLES    = 5,
  parameter int unsigned LIFE_CYCLES  = 50000000,
  parameter int unsigned FLASH_CYCLES = 12500000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   load,
  input  logic [NUM_MOLES-1:0]   molesGenerated,
  input  logic [2:0]             userGameInput,
  output logic [2*NUM_MOLES-1:0] moleState,
  output logic [NUM_MOLES-1:0]   moleHit,
  output logic                   moleMiss,
  output logic                   wrongHit,
  output logic                   allClear
);

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StOn   = 2'b01,
    StHit  = 2'b10,
    StMiss = 2'b11
  } mole_state_e;

  localparam logic [CNT_W-1:0] LifeInit  = CNT_W'(LIFE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FlashInit = CNT_W'(FLASH_CYCLES - 1);

  mole_state_e            state_q [NUM_MOLES];
  mole_state_e            state_d [NUM_MOLES];
  logic [CNT_W-1:0]       timer_q [NUM_MOLES];
  logic [CNT_W-1:0]       timer_d [NUM_MOLES];
  logic [2:0]             cur_in_q, cur_in_d;
  logic [2:0]             prev_in_q, prev_in_d;
  logic [NUM_MOLES-1:0]   hit_q, hit_d;
  logic                   miss_q, miss_d;
  logic                   wrong_q, wrong_d;
  logic                   press_event;
  logic [NUM_MOLES-1:0]   press_sel;
  logic [CNT_W-1:0]       life_reload;

`ifdef MOLE_SPEEDUP_EN
  localparam logic [CNT_W-1:0] LifeStep  = CNT_W'(LIFE_CYCLES / 16);
  localparam logic [CNT_W-1:0] LifeFloor = CNT_W'(LIFE_CYCLES / 4 - 1);

  logic [CNT_W-1:0] life_reload_q, life_reload_d;

  assign life_reload = life_reload_q;

  // Shrink the lifetime once per hit pulse, never below a quarter of the nominal lifetime.
  always_comb begin
    life_reload_d = life_reload_q;
    if (clear) begin
      life_reload_d = LifeInit;
    end else if (|hit_d) begin
      if (life_reload_q >= LifeFloor + LifeStep) begin
        life_reload_d = life_reload_q - LifeStep;
      end else begin
        life_reload_d = LifeFloor;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      life_reload_q <= LifeInit;
    end else begin
      life_reload_q <= life_reload_d;
    end
  end
`else
  assign life_reload = LifeInit;
`endif

  // One event per press: code went from 0 to non-zero.
  assign press_event = (cur_in_q != 3'd0) && (prev_in_q == 3'd0);

  always_comb begin
    press_sel = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      press_sel[i] = press_event && (cur_in_q == 3'(i + 1));
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MOLES; i++) begin
        state_q[i] <= StOff;
        timer_q[i] <= '0;
      end
      cur_in_q  <= 3'd0;
      prev_in_q <= 3'd0;
      hit_q     <= '0;
      miss_q    <= 1'b0;
      wrong_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MOLES; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      cur_in_q  <= cur_in_d;
      prev_in_q <= prev_in_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      wrong_q   <= wrong_d;
    end
  end

  // Next-state logic; pulse flops default to 0 so disabled cycles emit nothing.
  always_comb begin
    for (int i = 0; i < NUM_MOLES; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
    end
    cur_in_d  = cur_in_q;
    prev_in_d = prev_in_q;
    hit_d     = '0;
    miss_d    = 1'b0;
    wrong_d   = 1'b0;
    if (clear) begin
      for (int i = 0; i < NUM_MOLES; i++) begin
        state_d[i] = StOff;
        timer_d[i] = '0;
      end
      cur_in_d  = 3'd0;
      prev_in_d = 3'd0;
    end else if (enable) begin
      cur_in_d  = (userGameInput > 3'd5) ? 3'd0 : userGameInput;
      prev_in_d = cur_in_q;
      for (int i = 0; i < NUM_MOLES; i++) begin
        unique case (state_q[i])
          StOff: begin
            if (load && molesGenerated[i]) begin
              state_d[i] = StOn;
              timer_d[i] = life_reload;
            end
          end
          StOn: begin
            // A press on the timeout cycle still counts as a hit.
            if (press_sel[i]) begin
              state_d[i] = StHit;
              timer_d[i] = FlashInit;
              hit_d[i]   = 1'b1;
            end else if (timer_q[i] == '0) begin
              state_d[i] = StMiss;
              timer_d[i] = FlashInit;
              miss_d     = 1'b1;
            end else begin
              timer_d[i] = timer_q[i] - 1'b1;
            end
          end
          StHit, StMiss: begin
            if (timer_q[i] == '0) begin
              state_d[i] = StOff;
            end else begin
              timer_d[i] = timer_q[i] - 1'b1;
            end
          end
        endcase
        if (press_sel[i] && (state_q[i] != StOn)) begin
          wrong_d = 1'b1;
        end
      end
    end
  end

  // Outputs.
  always_comb begin
    moleState = '0;
    allClear  = 1'b1;
    for (int i = 0; i < NUM_MOLES; i++) begin
      moleState[2*i +: 2] = state_q[i];
      if (state_q[i] != StOff) begin
        allClear = 1'b0;
      end
    end
    moleHit  = hit_q;
    moleMiss = miss_q;
    wrongHit = wrong_q;
  end

endmodule
